// File: rtl/sram_2p_masked_clr_pkg.sv
// Shared types and elaboration-time helpers for the two-port masked SRAM with post-reset clear.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int lane_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

    function automatic bit mask_ok(input int data_w, input int mask_w);
        return (mask_w > 0) && ((data_w % mask_w) == 0);
    endfunction

endpackage

// File: rtl/sram_2p_masked_clr_if.sv
// Request/response bundle for the RW0 (masked read/write) and R1 (read-only) ports.
interface sram_2p_masked_clr_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 96,
    parameter int MASK_W = 16
);
    // Handshake: no backpressure. A request is taken on any non-busy cycle where
    // its en is high; each taken read produces exactly one rvalid pulse RD_LAT
    // cycles later, in request order, and rdata holds until the next pulse.
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [MASK_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;
    logic              RW0_rvalid;
    logic [ADDR_W-1:0] R1_addr;
    logic              R1_en;
    logic [DATA_W-1:0] R1_rdata;
    logic              R1_rvalid;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, R1_addr, R1_en,
        input  RW0_rdata, RW0_rvalid, R1_rdata, R1_rvalid
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, R1_addr, R1_en,
        output RW0_rdata, RW0_rvalid, R1_rdata, R1_rvalid
    );

endinterface

// File: rtl/sram_2p_masked_clr_rd_pipe.sv
// Read-result pipeline: RD_LAT register stages of valid and data; data only advances with valid.
module sram_rd_pipe #(
    parameter int DATA_W = 96,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] v_q;
    logic [DATA_W-1:0] d_q [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < RD_LAT; k++) d_q[k] <= '0;
        end else begin
            v_q[0] <= in_valid;
            if (in_valid) d_q[0] <= in_data;
            for (int k = 1; k < RD_LAT; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) d_q[k] <= d_q[k-1];
            end
        end
    end

    assign out_valid = v_q[RD_LAT-1];
    assign out_data  = d_q[RD_LAT-1];

endmodule

// File: rtl/sram_2p_masked_clr.sv
// Two-port masked-write SRAM model with post-reset zeroing sequencer.
// Define SRAM_RDW_BYPASS_EN to forward same-cycle RW0 write lanes into a colliding R1 read.
module sram_2p_masked_clr
    import sram_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 96,
    parameter int MASK_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic       clock,
    input  logic       reset,
    output logic       init_busy,
    output clr_state_e state,
    sram_2p_masked_clr_if.slave bus
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANE_W = lane_w(DATA_W, MASK_W);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("sram_2p_masked_clr: RD_LAT must be 1 or 2");
    end
    if (!mask_ok(DATA_W, MASK_W)) begin : g_bad_mask
        $error("sram_2p_masked_clr: DATA_W must be a multiple of MASK_W");
    end

    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_fire;
    logic              rw0_rd;
    logic              r1_rd;
    logic [DATA_W-1:0] rw0_word;
    logic [DATA_W-1:0] r1_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= (CLR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt   <= '0;
            init_busy <= (CLR_ON_RESET != 0);
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (&clr_cnt) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                READY: begin
                end
            endcase
        end
    end

    assign wr_fire = (state == READY) && !reset && bus.RW0_en && bus.RW0_wmode;
    assign rw0_rd  = (state == READY) && bus.RW0_en && !bus.RW0_wmode;
    assign r1_rd   = (state == READY) && bus.R1_en;

    // The array itself is never reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge clock) begin
        if (!reset && state == CLEAR) begin
            ram[clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (bus.RW0_wmask[i])
                    ram[bus.RW0_addr][i*LANE_W +: LANE_W] <= bus.RW0_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rw0_word = ram[bus.RW0_addr];

`ifdef SRAM_RDW_BYPASS_EN
    always_comb begin
        r1_word = ram[bus.R1_addr];
        if (wr_fire && (bus.RW0_addr == bus.R1_addr)) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (bus.RW0_wmask[i])
                    r1_word[i*LANE_W +: LANE_W] = bus.RW0_wdata[i*LANE_W +: LANE_W];
            end
        end
    end
`else
    assign r1_word = ram[bus.R1_addr];
`endif

    sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rw0_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rw0_rd),
        .in_data   (rw0_word),
        .out_valid (bus.RW0_rvalid),
        .out_data  (bus.RW0_rdata)
    );

    sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_r1_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (r1_rd),
        .in_data   (r1_word),
        .out_valid (bus.R1_rvalid),
        .out_data  (bus.R1_rdata)
    );

endmodule
